// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and colour types for the VGA source
// and the renderers that consume its pixel coordinates.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int COLOR_W = 24;
  localparam int CNT_W   = 10;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

endpackage

// File: rtl/pixel_clk_div.sv
// Pixel-rate enable and DAC clock from the system clock. CLK_DIV must be
// even and >= 2 so VGA_CLK has a 50% duty cycle.
module pixel_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en,
  output logic vga_clk
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] D_HALF = DW'(CLK_DIV / 2);

  logic [DW-1:0] d;
  logic [DW-1:0] d_next;

  // Next divider phase, wrapping after the last clk of a pixel.
  always_comb begin
    d_next = (d == D_LAST) ? '0 : d + 1'b1;
  end

  assign pix_en = (d == D_LAST);

  // Divider phase and DAC clock; VGA_CLK rises mid pixel so the DAC samples
  // settled data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d       <= '0;
      vga_clk <= 1'b0;
    end else begin
      d       <= d_next;
      vga_clk <= (d_next >= D_HALF);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing source: pixel/line counters, active and sync decode, and the
// registered DAC pin stage that keeps colour aligned with the syncs.
module vga_timing_gen
  import vga_pkg::COLOR_W, vga_pkg::CNT_W, vga_pkg::rgb_t;
#(
  parameter int H_ACTIVE    = vga_pkg::H_ACTIVE,
  parameter int H_FP        = vga_pkg::H_FP,
  parameter int H_SYNC      = vga_pkg::H_SYNC,
  parameter int H_BP        = vga_pkg::H_BP,
  parameter int V_ACTIVE    = vga_pkg::V_ACTIVE,
  parameter int V_FP        = vga_pkg::V_FP,
  parameter int V_SYNC      = vga_pkg::V_SYNC,
  parameter int V_BP        = vga_pkg::V_BP,
  parameter int CLK_DIV     = 2,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [CNT_W-1:0]   xPixel,
  output logic [CNT_W-1:0]   yPixel,
  output logic               active_pixels,
  output logic               frame_start,
  input  logic [COLOR_W-1:0] vga_color,
  output logic [7:0]         VGA_R,
  output logic [7:0]         VGA_G,
  output logic [7:0]         VGA_B,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_BLANK_N,
  output logic               VGA_SYNC_N,
  output logic               VGA_CLK
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic             pix_en;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             v_wrap;
  logic             hs_raw;
  logic             vs_raw;

  rgb_t             rgb_p1;
  logic             hs_p1;
  logic             vs_p1;
  logic             blank_n_p1;
  logic             frame_start_p1;

  pixel_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_clk_div (
    .clk     (clk),
    .rst     (rst),
    .pix_en  (pix_en),
    .vga_clk (VGA_CLK)
  );

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  // Pixel and line counters; the line advances on the same pix_en as the
  // column wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
      if (h_wrap) begin
        v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
      end
    end
  end

  // Stage p0: decode straight from the counters. Coordinates are not clamped;
  // the renderer qualifies them with active_pixels.
  assign xPixel        = h_cnt;
  assign yPixel        = v_cnt;
  assign active_pixels = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs_raw        = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
  assign vs_raw        = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);

  // Stage p1: DAC pin register, one pixel behind the coordinates, so the
  // renderer's combinational colour lands with its own syncs and blank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_p1         <= '0;
      hs_p1          <= ~SYNC_ACTIVE;
      vs_p1          <= ~SYNC_ACTIVE;
      blank_n_p1     <= 1'b0;
      frame_start_p1 <= 1'b0;
    end else begin
      frame_start_p1 <= pix_en && h_wrap && v_wrap;
      if (pix_en) begin
        rgb_p1     <= active_pixels ? rgb_t'(vga_color) : '0;
        hs_p1      <= hs_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vs_p1      <= vs_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        blank_n_p1 <= active_pixels;
      end
    end
  end

  assign VGA_R       = rgb_p1.r;
  assign VGA_G       = rgb_p1.g;
  assign VGA_B       = rgb_p1.b;
  assign VGA_HS      = hs_p1;
  assign VGA_VS      = vs_p1;
  assign VGA_BLANK_N = blank_n_p1;
  assign frame_start = frame_start_p1;
  assign VGA_SYNC_N  = 1'b0;

endmodule
